seg7_scan_decoder: RTL

Receive side of the team's 7-segment display interface. It watches a multiplexed segment bus (seg pattern, dp and one-hot digit select) and recovers the hex nibble and decimal-point bit for each digit. A debounce/settle filter ensures only stable patterns are captured. Once every digit has been captured, it presents the whole display as one frame with a valid/ready handshake. Used for loopback checking of display drivers and for reading external 7-segment display boards.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_pattern_decode.sv | 38 +++
 rtl/seg7_scan_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display interface: segment bit
// positions, the canonical hex glyph patterns (also used by the display
// encoder), the decode result type and the scan FSM state type.
package seg7_pkg;

  // Segment bit order within the 7-bit pattern (active-high).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG7_CODE_0 = 7'b1111110;
  localparam logic [6:0] SEG7_CODE_1 = 7'b0110000;
  localparam logic [6:0] SEG7_CODE_2 = 7'b1101101;
  localparam logic [6:0] SEG7_CODE_3 = 7'b1111001;
  localparam logic [6:0] SEG7_CODE_4 = 7'b0110011;
  localparam logic [6:0] SEG7_CODE_5 = 7'b1011011;
  localparam logic [6:0] SEG7_CODE_6 = 7'b1011111;
  localparam logic [6:0] SEG7_CODE_7 = 7'b1110000;
  localparam logic [6:0] SEG7_CODE_8 = 7'b1111111;
  localparam logic [6:0] SEG7_CODE_9 = 7'b1111011;
  localparam logic [6:0] SEG7_CODE_A = 7'b1110111;
  localparam logic [6:0] SEG7_CODE_B = 7'b0011111;
  localparam logic [6:0] SEG7_CODE_C = 7'b1001110;
  localparam logic [6:0] SEG7_CODE_D = 7'b0111101;
  localparam logic [6:0] SEG7_CODE_E = 7'b1001111;
  localparam logic [6:0] SEG7_CODE_F = 7'b1000111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       err;
  } seg7_decode_t;

  typedef enum logic {
    SCAN_SETTLING = 1'b0,
    SCAN_LOCKED   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Combinational lookup from a 7-segment pattern to its hex value.
// Patterns outside the glyph table decode to nibble 0 with err set.
// Ports:
//   i_pattern  7-bit segment pattern, bit6=a .. bit0=g
//   o_decode   {nibble, err}
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]   i_pattern,
  output seg7_decode_t o_decode
);

  always_comb begin
    o_decode.nibble = 4'h0;
    o_decode.err    = 1'b0;
    unique case (i_pattern)
      SEG7_CODE_0: o_decode.nibble = 4'h0;
      SEG7_CODE_1: o_decode.nibble = 4'h1;
      SEG7_CODE_2: o_decode.nibble = 4'h2;
      SEG7_CODE_3: o_decode.nibble = 4'h3;
      SEG7_CODE_4: o_decode.nibble = 4'h4;
      SEG7_CODE_5: o_decode.nibble = 4'h5;
      SEG7_CODE_6: o_decode.nibble = 4'h6;
      SEG7_CODE_7: o_decode.nibble = 4'h7;
      SEG7_CODE_8: o_decode.nibble = 4'h8;
      SEG7_CODE_9: o_decode.nibble = 4'h9;
      SEG7_CODE_A: o_decode.nibble = 4'hA;
      SEG7_CODE_B: o_decode.nibble = 4'hB;
      SEG7_CODE_C: o_decode.nibble = 4'hC;
      SEG7_CODE_D: o_decode.nibble = 4'hD;
      SEG7_CODE_E: o_decode.nibble = 4'hE;
      SEG7_CODE_F: o_decode.nibble = 4'hF;
      default:     o_decode.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed 7-segment bus and rebuilds the displayed frame.
// Each digit is captured once its sample has been stable for
// STABLE_CYCLES cycles; when every digit has been captured the frame is
// offered on a valid/ready handshake.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   seg_in, dp_in  segment pattern (bit6=a .. bit0=g) and decimal point
//   dig_sel        one-hot digit strobe
//   frame_value    nibble per digit, digit i in [4i+3:4i]
//   frame_dp       dp per digit
//   frame_err      1 = digit pattern not a hex glyph
//   frame_valid    frame available
//   frame_ready    consumer accepts frame
//   overrun        one-cycle pulse, completed frame dropped
//
// state    | meaning
// SETTLING | waiting for the sample to be stable STABLE_CYCLES cycles
// LOCKED   | current sample already captured, wait for it to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic                    dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic [NUM_DIGITS-1:0]   frame_dp,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_slot_val;
  logic [NUM_DIGITS-1:0]   r_slot_dp;
  logic [NUM_DIGITS-1:0]   r_slot_err;
  scan_state_t             r_state;

  scan_state_t             w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_change;
  logic                    w_in_onehot;
  logic                    w_capture;
  logic                    w_complete;
  logic [NUM_DIGITS-1:0]   w_seen_cap;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [4*NUM_DIGITS-1:0] w_slot_val;
  logic [NUM_DIGITS-1:0]   w_slot_dp;
  logic [NUM_DIGITS-1:0]   w_slot_err;
  seg7_decode_t            w_dec;

  seg7_pattern_decode u_decode (
    .i_pattern (r_seg),
    .o_decode  (w_dec)
  );

  // Stability counter is driven by the incoming bus against the sample
  // register, so it advances on the same edge the sample is taken.
  always_comb begin
    w_change    = ({seg_in, dp_in, dig_sel} != {r_seg, r_dp, r_sel});
    w_in_onehot = (dig_sel != '0) &&
                  ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    w_cnt_next  = r_cnt;
    if (!w_in_onehot)
      w_cnt_next = '0;
    else if (w_change)
      w_cnt_next = CNT_W'(1);
    else if (r_cnt != CNT_MAX)
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  // A non-zero count implies the registered strobe is one-hot.
  always_comb begin
    w_capture    = (r_state == SCAN_SETTLING) && (r_cnt == CNT_MAX);
    w_state_next = r_state;
    // A bus change wins over a simultaneous capture so the new sample
    // is not lost behind LOCKED.
    if (w_change)
      w_state_next = SCAN_SETTLING;
    else if (w_capture)
      w_state_next = SCAN_LOCKED;
  end

  // Slot contents including the current capture; the frame copy uses
  // these so the last digit appears in the frame it completes.
  always_comb begin
    w_slot_val = r_slot_val;
    w_slot_dp  = r_slot_dp;
    w_slot_err = r_slot_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_capture && r_sel[i]) begin
        w_slot_val[4*i +: 4] = w_dec.nibble;
        w_slot_dp[i]         = r_dp;
        w_slot_err[i]        = w_dec.err;
      end
    end
    w_seen_cap  = r_seen | (w_capture ? r_sel : '0);
    w_complete  = w_capture && (&w_seen_cap);
    w_seen_next = w_complete ? '0 : w_seen_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= SCAN_SETTLING;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= '0;
      r_dp       <= 1'b0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_seen     <= '0;
      r_slot_val <= '0;
      r_slot_dp  <= '0;
      r_slot_err <= '0;
    end else begin
      r_seg      <= seg_in;
      r_dp       <= dp_in;
      r_sel      <= dig_sel;
      r_cnt      <= w_cnt_next;
      r_seen     <= w_seen_next;
      r_slot_val <= w_slot_val;
      r_slot_dp  <= w_slot_dp;
      r_slot_err <= w_slot_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_value <= '0;
      frame_dp    <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_complete) begin
        if (!frame_valid || frame_ready) begin
          frame_value <= w_slot_val;
          frame_dp    <= w_slot_dp;
          frame_err   <= w_slot_err;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
